sram_2p_init: RTL and testbench

- Parametrised successor to the single-port node-table SRAM.
- Provides one write port and one independent read port in the same clock domain.
- Read latency is configurable (1 or 2 cycles), with a valid flag, write-first bypass, and a hardware init sweep that fills memory with a known value after reset or on request.
- Sits between the BDD node-construction logic (writer) and the traversal engine (reader), holding packed node entries of {var, lo, hi, id} fields.

---
 rtl/bdd_mem_pkg.sv | 28 ++
 rtl/sram_rd_pipe.sv | 54 +++++
 rtl/sram_2p_init.sv | 233 +++++++++++++++++++++++
 tb/tb_sram_2p_init.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bdd_mem_pkg.sv
// ----------------------------------------------------------------------------
// bdd_mem_pkg
// Shared definitions for the BDD node-table memory slice.
//   - Node entry field widths: {var, lo, hi, id} packs into NODE_W bits.
//   - FSM state type for the init-sweep controller.
//   - Legal read-latency values and a helper that checks them.
// ----------------------------------------------------------------------------
package bdd_mem_pkg;

    localparam int VAR_W  = 8;
    localparam int LO_W   = 8;
    localparam int HI_W   = 8;
    localparam int ID_W   = 10;
    localparam int NODE_W = VAR_W + LO_W + HI_W + ID_W;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } mem_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_latency_ok(input int lat);
        return (lat == RD_LAT_MIN) || (lat == RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// ----------------------------------------------------------------------------
// sram_rd_pipe
// LATENCY-deep delay line for read valid and read payload. The payload
// carries the read data and, when parity is built in, the parity-error flag
// in its top bit. Each payload stage only loads when the stage feeding it is
// valid, so the final stage holds the last delivered word while idle.
//
// Ports:
//   i_clk    in   clock, rising edge
//   i_rst_n  in   asynchronous active-low reset; clears valids and payload
//   i_valid  in   a read was accepted this cycle
//   i_data   in   payload looked up this cycle
//   o_valid  out  payload delivered this cycle (LATENCY cycles after i_valid)
//   o_data   out  delivered payload, held while o_valid is low
// ----------------------------------------------------------------------------
module sram_rd_pipe #(
    parameter int LATENCY    = 1,
    parameter int DATA_WIDTH = 34
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [LATENCY-1:0]    valid_q;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q[0] <= i_valid;
            if (i_valid) begin
                data_q[0] <= i_data;
            end
            for (int s = 1; s < LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                if (valid_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign o_valid = valid_q[LATENCY-1];
    assign o_data  = data_q[LATENCY-1];

endmodule

// File: rtl/sram_2p_init.sv
// ----------------------------------------------------------------------------
// sram_2p_init
// Two-port (one write, one read) node-table SRAM with a hardware init sweep.
// After reset, or on i_clear while READY, the controller writes INIT_VALUE to
// every word, one per cycle, before user accesses are accepted. Reads are
// write-first and have a configurable latency of 1 or 2 cycles.
//
// Optional build macro SRAM_PARITY_EN: stores an even-parity bit with every
// word, adds i_wr_par_flip (error injection) and o_parity_err (aligned with
// o_rd_valid).
//
// Ports:
//   i_clk          in   clock, rising edge
//   i_rst_n        in   asynchronous active-low reset
//   i_clear        in   start a new init sweep (only sampled while READY)
//   i_wr_en        in   write request
//   i_wr_addr      in   write address
//   i_wr_data      in   write data
//   i_rd_en        in   read request
//   i_rd_addr      in   read address
//   i_wr_par_flip  in   (SRAM_PARITY_EN) invert the stored parity bit
//   o_rd_data      out  read data, held while o_rd_valid is low
//   o_rd_valid     out  o_rd_data valid this cycle
//   o_parity_err   out  (SRAM_PARITY_EN) stored parity mismatch on this read
//   o_ready        out  user accesses accepted
//
// Handshake: there is no back-pressure. A request is accepted exactly when
// its enable is high in a cycle where o_ready is high; o_rd_valid pulses for
// one cycle RD_LATENCY cycles after each accepted read.
// ----------------------------------------------------------------------------
module sram_2p_init
    import bdd_mem_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 5,
    parameter int                   DATA_WIDTH = NODE_W,
    parameter int                   DEPTH      = 32,
    parameter int                   RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
`ifdef SRAM_PARITY_EN
    input  logic                  i_wr_par_flip,
    output logic                  o_parity_err,
`endif
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_ready
);

    // ------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------
    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("sram_2p_init: RD_LATENCY must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("sram_2p_init: DEPTH must be in 1..2**ADDR_WIDTH");
    end

`ifdef SRAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_WIDTH + PAR_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Counter is one bit wider than the address so a full 2**ADDR_WIDTH
    // sweep can terminate without wrapping.
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_C  = (ADDR_WIDTH + 1)'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Init-sweep FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    mem_state_t            state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == LAST_C) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (i_clear) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    logic             ready;
    logic             sweep_we;
    logic [IDX_W-1:0] sweep_addr;

    always_comb begin
        ready      = (state_q == ST_READY);
        sweep_we   = (state_q == ST_INIT);
        sweep_addr = cnt_q[IDX_W-1:0];
    end

    assign o_ready = ready;

    // ------------------------------------------------------------------
    // Word formatting (data plus optional parity bit)
    // ------------------------------------------------------------------
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] init_word;

`ifdef SRAM_PARITY_EN
    assign wr_word   = {(^i_wr_data) ^ i_wr_par_flip, i_wr_data};
    assign init_word = {^INIT_VALUE, INIT_VALUE};
`else
    assign wr_word   = i_wr_data;
    assign init_word = INIT_VALUE;
`endif

    // ------------------------------------------------------------------
    // Storage and write port (no reset on the array)
    // ------------------------------------------------------------------
    logic [MEM_W-1:0] mem [DEPTH];

    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_hit;
    logic             rd_fire;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [MEM_W-1:0] mem_wdata;

    always_comb begin
        wr_in_range = ({1'b0, i_wr_addr} < DEPTH_C);
        rd_in_range = ({1'b0, i_rd_addr} < DEPTH_C);
        wr_hit      = ready && i_wr_en && wr_in_range;
        rd_fire     = ready && i_rd_en;

        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_addr;
            mem_wdata = init_word;
        end else if (wr_hit) begin
            mem_we    = 1'b1;
            mem_waddr = i_wr_addr[IDX_W-1:0];
            mem_wdata = wr_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read lookup: out-of-range reads return zero, a same-cycle write to the
    // same address is forwarded (write-first).
    // ------------------------------------------------------------------
    logic [MEM_W-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (wr_hit && (i_wr_addr == i_rd_addr)) begin
                rd_word = wr_word;
            end else begin
                rd_word = mem[i_rd_addr[IDX_W-1:0]];
            end
        end
    end

    // Payload into the delay line: data, plus the parity verdict on top.
    logic [MEM_W-1:0] pipe_in;
    logic [MEM_W-1:0] pipe_out;

`ifdef SRAM_PARITY_EN
    assign pipe_in = {rd_word[DATA_WIDTH] ^ (^rd_word[DATA_WIDTH-1:0]),
                      rd_word[DATA_WIDTH-1:0]};
`else
    assign pipe_in = rd_word;
`endif

    sram_rd_pipe #(
        .LATENCY    (RD_LATENCY),
        .DATA_WIDTH (MEM_W)
    ) u_rd_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (rd_fire),
        .i_data  (pipe_in),
        .o_valid (o_rd_valid),
        .o_data  (pipe_out)
    );

    assign o_rd_data = pipe_out[DATA_WIDTH-1:0];

`ifdef SRAM_PARITY_EN
    // The held flag belongs to the last delivered word; only report it on
    // the cycle that word is valid.
    assign o_parity_err = o_rd_valid & pipe_out[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_sram_2p_init.sv
// ----------------------------------------------------------------------------
// tb_sram_2p_init
// Directed bench for sram_2p_init. Two instances share all inputs: one with
// RD_LATENCY=1, one with RD_LATENCY=2 (ADDR_WIDTH=6, DEPTH=32,
// INIT_VALUE=0x155), so every read sequence checks both latencies.
// ----------------------------------------------------------------------------
module tb_sram_2p_init;

    localparam int AW = 6;
    localparam int DW = 34;
    localparam logic [DW-1:0] IV = 34'h155;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          clear   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [DW-1:0] rd_data1, rd_data2;
    logic          rd_valid1, rd_valid2;
    logic          ready1, ready2;
`ifdef SRAM_PARITY_EN
    logic          par_flip = 1'b0;
    logic          perr1, perr2;
`endif

    int tests = 0;
    int fails = 0;

    // ---------------- clock / timeout ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    // ---------------- DUTs ----------------
    sram_2p_init #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH (32),
        .RD_LATENCY (1), .INIT_VALUE (IV)
    ) dut1 (
        .i_clk (clk), .i_rst_n (rst_n), .i_clear (clear),
        .i_wr_en (wr_en), .i_wr_addr (wr_addr), .i_wr_data (wr_data),
        .i_rd_en (rd_en), .i_rd_addr (rd_addr),
`ifdef SRAM_PARITY_EN
        .i_wr_par_flip (par_flip), .o_parity_err (perr1),
`endif
        .o_rd_data (rd_data1), .o_rd_valid (rd_valid1), .o_ready (ready1)
    );

    sram_2p_init #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .DEPTH (32),
        .RD_LATENCY (2), .INIT_VALUE (IV)
    ) dut2 (
        .i_clk (clk), .i_rst_n (rst_n), .i_clear (clear),
        .i_wr_en (wr_en), .i_wr_addr (wr_addr), .i_wr_data (wr_data),
        .i_rd_en (rd_en), .i_rd_addr (rd_addr),
`ifdef SRAM_PARITY_EN
        .i_wr_par_flip (par_flip), .o_parity_err (perr2),
`endif
        .o_rd_data (rd_data2), .o_rd_valid (rd_valid2), .o_ready (ready2)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues n back-to-back reads, then two idle cycles, checking both
    // latencies every cycle including the held data afterwards.
    task automatic read_seq(input string name, input int n,
                            input logic [AW-1:0] addrs[8], input logic [DW-1:0] exp[8]);
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) begin
                rd_en   = 1'b1;
                rd_addr = addrs[k];
            end else begin
                rd_en   = 1'b0;
            end
            tick();
            if (k < n) begin
                check($sformatf("%s_v1_%0d", name, k), 64'(rd_valid1), 64'd1);
                check($sformatf("%s_d1_%0d", name, k), 64'(rd_data1), 64'(exp[k]));
            end else begin
                check($sformatf("%s_v1_%0d", name, k), 64'(rd_valid1), 64'd0);
                check($sformatf("%s_h1_%0d", name, k), 64'(rd_data1), 64'(exp[n-1]));
            end
            if (k == 0) begin
                check($sformatf("%s_v2_%0d", name, k), 64'(rd_valid2), 64'd0);
            end else if (k <= n) begin
                check($sformatf("%s_v2_%0d", name, k), 64'(rd_valid2), 64'd1);
                check($sformatf("%s_d2_%0d", name, k), 64'(rd_data2), 64'(exp[k-1]));
            end else begin
                check($sformatf("%s_v2_%0d", name, k), 64'(rd_valid2), 64'd0);
                check($sformatf("%s_h2_%0d", name, k), 64'(rd_data2), 64'(exp[n-1]));
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [AW-1:0] a[8];
    logic [DW-1:0] e[8];
    int n;
    int v;

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ready1", 64'(ready1), 64'd0);
        check("rst_ready2", 64'(ready2), 64'd0);
        check("rst_valid1", 64'(rd_valid1), 64'd0);
        check("rst_valid2", 64'(rd_valid2), 64'd0);
        check("rst_data1", 64'(rd_data1), 64'd0);
        check("rst_data2", 64'(rd_data2), 64'd0);

        // Init sweep after reset: ready after exactly 32 INIT cycles
        rst_n = 1'b1;
        n = 0;
        while (!ready1 && n < 100) begin
            tick();
            n++;
        end
        check("init_len", 64'(n), 64'd32);
        check("init_ready2", 64'(ready2), 64'd1);

        a = '{6'd0, 6'd31, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        e = '{IV, IV, IV, IV, IV, IV, IV, IV};
        read_seq("init_rd", 2, a, e);

        // Node entries {10, lo=i, 0, 245} to addresses 0..7
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = {8'd10, 8'(i), 8'd0, 10'd245};
            tick();
        end
        wr_en = 1'b0;
        a = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7};
        e = '{34'h280000F5, 34'h280400F5, 34'h280800F5, 34'h280C00F5,
              34'h281000F5, 34'h281400F5, 34'h281800F5, 34'h281C00F5};
        read_seq("burst", 8, a, e);

        // Write-first: same-cycle write and read of address 3
        wr_en   = 1'b1;
        wr_addr = 6'd3;
        wr_data = {8'd10, 8'd3, 8'd0, 10'd485};
        rd_en   = 1'b1;
        rd_addr = 6'd3;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("wf_v1", 64'(rd_valid1), 64'd1);
        check("wf_d1", 64'(rd_data1), 64'h280C01E5);
        tick();
        check("wf_v2", 64'(rd_valid2), 64'd1);
        check("wf_d2", 64'(rd_data2), 64'h280C01E5);
        check("wf_idle1", 64'(rd_valid1), 64'd0);
        tick();
        a = '{6'd3, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        e = '{34'h280C01E5, 34'h0, 34'h0, 34'h0, 34'h0, 34'h0, 34'h0, 34'h0};
        read_seq("wf_after", 1, a, e);

        // Out of range: write to 40 dropped (must not alias to 8), read gives 0
        wr_en   = 1'b1;
        wr_addr = 6'd40;
        wr_data = 34'h3_FFFF_FFFF;
        tick();
        wr_en = 1'b0;
        a = '{6'd40, 6'd8, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        e = '{34'h0, IV, 34'h0, 34'h0, 34'h0, 34'h0, 34'h0, 34'h0};
        read_seq("oor", 2, a, e);

        // Clear with accesses in the same cycle (still honoured)
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 6'd9;
        wr_data = 34'h1111;
        rd_en   = 1'b1;
        rd_addr = 6'd2;
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("clr_ready", 64'(ready1), 64'd0);
        check("clr_v1", 64'(rd_valid1), 64'd1);
        check("clr_d1", 64'(rd_data1), 64'h280800F5);
        // Sweep length, with a write/read to addr 4 attempted mid-sweep
        n = 0;
        v = 0;
        while (!ready1 && n < 100) begin
            if (n == 10) begin
                wr_en   = 1'b1;
                wr_addr = 6'd4;
                wr_data = 34'h3FF;
                rd_en   = 1'b1;
                rd_addr = 6'd4;
            end else begin
                wr_en = 1'b0;
                rd_en = 1'b0;
            end
            tick();
            n++;
            if (n == 1) begin
                check("clr_v2", 64'(rd_valid2), 64'd1);
                check("clr_d2", 64'(rd_data2), 64'h280800F5);
            end else if (rd_valid2) begin
                v++;
            end
            if (rd_valid1) v++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("clr_len", 64'(n), 64'd32);
        check("init_no_valid", 64'(v), 64'd0);
        a = '{6'd0, 6'd3, 6'd4, 6'd7, 6'd8, 6'd9, 6'd0, 6'd0};
        e = '{IV, IV, IV, IV, IV, IV, IV, IV};
        read_seq("clr_rd", 6, a, e);

        // Async reset with reads in flight
        wr_en   = 1'b1;
        wr_addr = 6'd5;
        wr_data = 34'h1234;
        tick();
        wr_addr = 6'd31;
        wr_data = 34'h2A;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 6'd0;
        tick();
        rd_addr = 6'd1;
        tick();
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_v1", 64'(rd_valid1), 64'd0);
        check("arst_v2", 64'(rd_valid2), 64'd0);
        check("arst_d1", 64'(rd_data1), 64'd0);
        check("arst_ready", 64'(ready1), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_drop2", 64'(rd_valid2), 64'd0);
        // Reset again at the 10th INIT cycle
        repeat (9) tick();
        check("mid_ready", 64'(ready1), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!ready1 && n < 100) begin
            tick();
            n++;
        end
        check("restart_len", 64'(n), 64'd32);
        a = '{6'd0, 6'd5, 6'd31, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        e = '{IV, IV, IV, IV, IV, IV, IV, IV};
        read_seq("restart_rd", 3, a, e);

`ifdef SRAM_PARITY_EN
        // Parity error injection, then a clean rewrite
        wr_en    = 1'b1;
        wr_addr  = 6'd5;
        wr_data  = 34'h2222;
        par_flip = 1'b1;
        tick();
        wr_en    = 1'b0;
        par_flip = 1'b0;
        rd_en    = 1'b1;
        rd_addr  = 6'd5;
        tick();
        rd_en = 1'b0;
        check("par_v1", 64'(rd_valid1), 64'd1);
        check("par_err1", 64'(perr1), 64'd1);
        tick();
        check("par_err2", 64'(perr2), 64'd1);
        wr_en   = 1'b1;
        wr_data = 34'h2222;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("par_ok1", 64'(perr1), 64'd0);
        check("par_okv1", 64'(rd_valid1), 64'd1);
        tick();
        check("par_ok2", 64'(perr2), 64'd0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
